// File: rtl/bouncing_tile_engine.sv
// Multi-sprite bouncing tile engine: steps NUM_SPRITES tiles on a grid every STEP_DIV frames
// and renders them with one cycle of latency, keeping sync aligned with colour.
module bouncing_tile_engine #(
  parameter int NUM_SPRITES = 2,
  parameter int TILE_SHIFT  = 5,
  parameter int GRID_W      = 20,
  parameter int GRID_H      = 15,
  parameter int STEP_DIV    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [9:0]               hpos,
  input  logic [9:0]               vpos,
  input  logic                     display_on,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic                     pause,
  input  logic [2*NUM_SPRITES-1:0] init_dir,
  input  logic [5:0]               fg_color,
  input  logic [5:0]               bg_color,
  output logic [5:0]               rgb,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic [7:0]               corner_count,
  output logic                     corner_pulse
);
  // A one-tile grid still needs a 1-bit coordinate register.
  localparam int XW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int YW = (GRID_H > 1) ? $clog2(GRID_H) : 1;

  logic [XW-1:0]          r_x   [NUM_SPRITES];
  logic [YW-1:0]          r_y   [NUM_SPRITES];
  logic [1:0]             r_rot [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] r_dx;
  logic [NUM_SPRITES-1:0] r_dy;
  logic [7:0]             r_div;
  logic                   r_vsync_prev;
  logic                   r_armed;
  logic [7:0]             r_count;
  logic                   r_pulse;
  logic [5:0]             r_rgb;
  logic                   r_hs;
  logic                   r_vs;

  logic                   w_tick;
  logic                   w_step;
  logic [NUM_SPRITES-1:0] w_flip_x;
  logic [NUM_SPRITES-1:0] w_flip_y;
  logic [NUM_SPRITES-1:0] w_hit;
  logic [5:0]             w_color [NUM_SPRITES];
  logic [2:0]             w_num_corners;
  logic [8:0]             w_count_sum;
  logic [9:0]             w_tx;
  logic [9:0]             w_ty;
  logic [5:0]             w_pix;

  // r_armed suppresses a tick until vsync has been seen low after reset.
  assign w_tick = vsync_in & ~r_vsync_prev & r_armed;
  assign w_step = w_tick & ~pause & (r_div == 8'(STEP_DIV - 1));
  assign w_tx   = hpos >> TILE_SHIFT;
  assign w_ty   = vpos >> TILE_SHIFT;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_sprite
      assign w_flip_x[gi] = r_dx[gi] ? (r_x[gi] == XW'(GRID_W - 1)) : (r_x[gi] == '0);
      assign w_flip_y[gi] = r_dy[gi] ? (r_y[gi] == YW'(GRID_H - 1)) : (r_y[gi] == '0);
      assign w_hit[gi]    = (w_tx == 10'(r_x[gi])) && (w_ty == 10'(r_y[gi]));
      assign w_color[gi]  = (r_rot[gi] == 2'd1) ? {fg_color[3:0], fg_color[5:4]} :
                            (r_rot[gi] == 2'd2) ? {fg_color[1:0], fg_color[5:2]} :
                                                  fg_color;
    end
  endgenerate

  always_comb begin
    w_num_corners = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      w_num_corners = w_num_corners + 3'(w_flip_x[i] & w_flip_y[i]);
    end
    w_count_sum = {1'b0, r_count} + 9'(w_num_corners);
  end

  // Scan from the highest index down so the lowest-index hit wins.
  always_comb begin
    w_pix = bg_color;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_hit[i]) w_pix = w_color[i];
    end
    if (!display_on) w_pix = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vsync_prev <= 1'b0;
      r_armed      <= 1'b0;
      r_div        <= '0;
      r_count      <= '0;
      r_pulse      <= 1'b0;
      r_rgb        <= '0;
      r_hs         <= 1'b0;
      r_vs         <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_x[i]   <= XW'((5 * i) % GRID_W);
        r_y[i]   <= YW'((3 * i + 1) % GRID_H);
        r_dx[i]  <= init_dir[2*i+1];
        r_dy[i]  <= init_dir[2*i];
        r_rot[i] <= 2'd0;
      end
    end else begin
      r_vsync_prev <= vsync_in;
      if (!vsync_in) r_armed <= 1'b1;
      if (w_tick && !pause) r_div <= (r_div == 8'(STEP_DIV - 1)) ? 8'd0 : r_div + 8'd1;
      r_pulse <= w_step && (w_num_corners != 3'd0);
      if (w_step) begin
        r_count <= w_count_sum[8] ? 8'hFF : w_count_sum[7:0];
        for (int i = 0; i < NUM_SPRITES; i++) begin
          if (w_flip_x[i]) r_dx[i] <= ~r_dx[i];
          else r_x[i] <= r_dx[i] ? r_x[i] + XW'(1) : r_x[i] - XW'(1);
          if (w_flip_y[i]) r_dy[i] <= ~r_dy[i];
          else r_y[i] <= r_dy[i] ? r_y[i] + YW'(1) : r_y[i] - YW'(1);
          if (w_flip_x[i] || w_flip_y[i]) r_rot[i] <= (r_rot[i] == 2'd2) ? 2'd0 : r_rot[i] + 2'd1;
        end
      end
      r_rgb <= w_pix;
      r_hs  <= hsync_in;
      r_vs  <= vsync_in;
    end
  end

  assign rgb          = r_rgb;
  assign hsync_out    = r_hs;
  assign vsync_out    = r_vs;
  assign corner_count = r_count;
  assign corner_pulse = r_pulse;
endmodule
